idu_addr_stage: RTL and testbench
=================================

IDU_ADDR_STAGE -- requirements
Module: idu_addr_stage

Interface
REQ-001 SHALL have parameter W, default 16, meaning the address/register datapath width.
REQ-002 SHALL have port CLK, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port n_RES, input, 1, meaning reset; synchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, meaning the upstream register file presents an operand.
REQ-005 SHALL have port in_ready, output, 1, meaning the stage accepts the operand this cycle.
REQ-006 SHALL have port in_addr, input, W, meaning the operand (PC, SP, BC, DE, HL, IX or IY value).
REQ-007 SHALL have port in_op, input, 2, meaning 00 PASS, 01 INC, 10 DEC, 11 reserved.
REQ-008 SHALL have port out_valid, output, 1, meaning the result is held for write-back.
REQ-009 SHALL have port out_ready, input, 1, meaning write-back consumes the result this cycle.
REQ-010 SHALL have port out_addr, output, W, meaning the registered result.
REQ-011 SHALL have port out_zero, output, 1, meaning out_addr equals 0; used for BC=0 termination of block instructions.
REQ-012 SHALL have port out_wrap, output, 1, meaning INC of all-ones or DEC of all-zeros occurred.
REQ-013 SHALL have port busy, output, 1, meaning the state is not IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, CALC and HOLD.
REQ-015 SHALL assert in_ready in IDLE, and in HOLD when out_ready=1; in_ready SHALL be 0 in CALC.
REQ-016 SHALL, on an edge with in_valid&in_ready, latch in_addr and in_op into operand registers and enter CALC.
REQ-017 SHALL, in CALC, compute the result from the latched operand through the carry sub-module, register out_addr, out_zero and out_wrap at the next edge, and enter HOLD.
REQ-018 SHALL, for INC, produce operand+1 mod 2^W; for DEC, operand-1 mod 2^W; for PASS and reserved 11, the operand unchanged with out_wrap=0.
REQ-019 SHALL assert out_valid only in HOLD and hold out_addr, out_zero and out_wrap stable until the handshake completes.
REQ-020 SHALL, in HOLD with out_ready=1, go to CALC when in_valid=1 (back-to-back accept), else go to IDLE.
REQ-021 SHALL stay in HOLD while out_ready=0, ignoring in_valid.
REQ-022 SHALL have a latency of 2 edges from accept to out_valid, and a throughput of one result per 2 cycles.
REQ-023 SHALL compute out_zero from the result value, not the operand; for example DEC 0001 gives out_zero=1 and out_wrap=0.

Reset
REQ-024 SHALL, on an edge with n_RES=0, enter IDLE and clear out_valid, out_addr, out_zero, out_wrap and the operand registers.
REQ-025 SHALL, on reset in CALC or HOLD, discard the in-flight operation with no result delivered; reset SHALL take priority over every handshake on the same edge.
REQ-026 SHALL assert in_ready on the first cycle after n_RES returns to 1.

Structure
REQ-027 SHALL place the op encodings, the state enum and the default W in a shared package, t84c_idu_pkg.
REQ-028 SHALL place the combinational carry chain in one sub-module, idu_carry.
REQ-029 SHALL make idu_carry a W-bit incrementer/decrementer built from 4-bit lookahead groups, producing the result and a carry/borrow-out that drives out_wrap.

Verification
REQ-030 SHALL cover INC at 1234, out_ready=1: in_ready=0 during CALC; out_valid 2 edges after accept; out_addr=1235, out_zero=0, out_wrap=0.
REQ-031 SHALL cover INC at FFFF, then DEC at 0000: results 0000 with out_zero=1, out_wrap=1, and FFFF with out_zero=0, out_wrap=1.
REQ-032 SHALL cover DEC at 0001 (BC block loop end): out_addr=0000, out_zero=1, out_wrap=0; reserved op 11 at ABCD gives ABCD with out_wrap=0.
REQ-033 SHALL cover out_ready=0 for 3 cycles in HOLD with in_valid=1: out_addr stable, in_ready=0; then out_ready=1 accepts the next operand that same edge (back-to-back).
REQ-034 SHALL cover n_RES=0 asserted in CALC: on the next cycle busy=0, out_valid=0, out_addr=0000, and no result appears later.
REQ-035 SHALL cover a random regression of 10k operands against a +1/-1 model, with carry boundaries 00FF, 0FFF, 7FFF and 8000 forced.

Source files
------------

// File: rtl/t84c_idu_pkg.sv
// Shared definitions for the IDU address stage: operation encodings, FSM states
// and the default datapath width.
package t84c_idu_pkg;

    localparam int IDU_W_DEFAULT = 16;
    localparam int IDU_GROUP_W   = 4;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_RSVD = 2'b11
    } idu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_HOLD = 2'b10
    } idu_state_e;

    function automatic logic op_counts(input logic [1:0] op);
        return (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/idu_carry.sv
// W-bit incrementer/decrementer built from 4-bit lookahead groups.
// carry_out is the carry (INC) or borrow (DEC) out of the top bit.
module idu_carry
    import t84c_idu_pkg::*;
#(
    parameter int W = IDU_W_DEFAULT
) (
    input  logic [W-1:0] operand,
    input  logic [1:0]   op,
    output logic [W-1:0] result,
    output logic         carry_out
);

    localparam int NG = (W + IDU_GROUP_W - 1) / IDU_GROUP_W;
    localparam int PW = NG * IDU_GROUP_W;

    logic          is_dec;
    logic          cin;
    logic [PW-1:0] t_pad;
    logic [PW-1:0] s_pad;
    logic [NG-1:0] grp_p;
    logic [NG:0]   grp_c;

    assign is_dec = (op == OP_DEC);
    assign cin    = op_counts(op);

    // Decrement is done as ~(~x + 1); padding with ones lets the top group's
    // carry-out stand for the carry out of bit W-1.
    always_comb begin
        t_pad          = '1;
        t_pad[W-1:0]   = is_dec ? ~operand : operand;
    end

    always_comb begin
        grp_p = '0;
        for (int g = 0; g < NG; g++) begin
            grp_p[g] = &t_pad[g*IDU_GROUP_W +: IDU_GROUP_W];
        end
    end

    // Each group carry is cin ANDed with every lower group's propagate.
    always_comb begin
        logic run;
        run      = cin;
        grp_c    = '0;
        grp_c[0] = cin;
        for (int g = 0; g < NG; g++) begin
            run        = run & grp_p[g];
            grp_c[g+1] = run;
        end
    end

    always_comb begin
        logic c;
        s_pad = '0;
        c     = 1'b0;
        for (int g = 0; g < NG; g++) begin
            c = grp_c[g];
            for (int b = 0; b < IDU_GROUP_W; b++) begin
                s_pad[g*IDU_GROUP_W + b] = t_pad[g*IDU_GROUP_W + b] ^ c;
                c = c & t_pad[g*IDU_GROUP_W + b];
            end
        end
    end

    assign result    = is_dec ? ~s_pad[W-1:0] : s_pad[W-1:0];
    assign carry_out = grp_c[NG];

endmodule

// File: rtl/idu_addr_stage.sv
// Address increment/decrement stage between the register file and write-back,
// with a valid/ready handshake on each side and one result per two cycles.
module idu_addr_stage
    import t84c_idu_pkg::*;
#(
    parameter int W = IDU_W_DEFAULT
) (
    input  logic         CLK,
    input  logic         n_RES,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_addr,
    input  logic [1:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_addr,
    output logic         out_zero,
    output logic         out_wrap,
    output logic         busy
);

    idu_state_e   state;
    idu_state_e   state_next;
    logic [W-1:0] opnd_addr;
    logic [1:0]   opnd_op;
    logic [W-1:0] calc_result;
    logic         calc_wrap;
    logic         accept;

    idu_carry #(.W(W)) u_carry (
        .operand   (opnd_addr),
        .op        (opnd_op),
        .result    (calc_result),
        .carry_out (calc_wrap)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_CALC;
            end
            ST_CALC: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                // Result held until write-back takes it; a waiting operand
                // is accepted on that same edge.
                if (out_ready) begin
                    in_ready   = 1'b1;
                    state_next = in_valid ? ST_CALC : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (!n_RES) begin
            state     <= ST_IDLE;
            opnd_addr <= '0;
            opnd_op   <= OP_PASS;
            out_addr  <= '0;
            out_zero  <= 1'b0;
            out_wrap  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                opnd_addr <= in_addr;
                opnd_op   <= in_op;
            end
            if (state == ST_CALC) begin
                out_addr <= calc_result;
                out_zero <= (calc_result == '0);
                out_wrap <= calc_wrap;
            end
        end
    end

endmodule

// File: tb/tb_idu_addr_stage.sv
// Self-checking bench for idu_addr_stage: directed corner cases plus a randomized
// regression against a transaction-level model of the stage.
module tb_idu_addr_stage;
    import t84c_idu_pkg::*;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         n_RES = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_addr = '0;
    logic [1:0]   in_op = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_addr;
    logic         out_zero;
    logic         out_wrap;
    logic         busy;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;
    int total_accepts = 0;

    // Model: an operand waiting to be computed, and a result waiting for write-back.
    bit           m_calc = 1'b0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_opnd = '0;
    logic [1:0]   m_op = 2'b00;
    logic [W-1:0] m_addr = '0;
    bit           m_zero = 1'b0;
    bit           m_wrap = 1'b0;

    always #5 CLK = ~CLK;

    idu_addr_stage #(.W(W)) dut (
        .CLK       (CLK),
        .n_RES     (n_RES),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_zero  (out_zero),
        .out_wrap  (out_wrap),
        .busy      (busy)
    );

    function automatic logic [17:0] ref_result(input logic [15:0] a, input logic [1:0] op);
        int         v;
        bit         wrap;
        logic [15:0] r;
        v    = int'(a);
        wrap = 1'b0;
        case (op)
            2'b01: begin
                v = v + 1;
                if (v == 65536) begin v = 0; wrap = 1'b1; end
            end
            2'b10: begin
                v = v - 1;
                if (v < 0) begin v = 65535; wrap = 1'b1; end
            end
            default: ;
        endcase
        r = v[15:0];
        return {(r == 16'h0000), wrap, r};
    endfunction

    function automatic bit m_in_ready();
        return !m_calc && (!m_valid || out_ready);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [15:0] addr, input logic [1:0] op, input bit ordy);
        @(posedge CLK);
        #1;
        in_valid  = v;
        in_addr   = addr;
        in_op     = op;
        out_ready = ordy;
    endtask

    // Model update on the active edge; inputs only change 1 time unit later.
    always @(posedge CLK) begin
        bit acc;
        bit fire;
        logic [17:0] r;
        if (!n_RES) begin
            m_calc  = 1'b0;
            m_valid = 1'b0;
            m_opnd  = '0;
            m_op    = 2'b00;
            m_addr  = '0;
            m_zero  = 1'b0;
            m_wrap  = 1'b0;
        end else begin
            acc  = in_valid && m_in_ready();
            fire = m_valid && out_ready;
            if (m_calc) begin
                r       = ref_result(m_opnd, m_op);
                m_addr  = r[15:0];
                m_wrap  = r[16];
                m_zero  = r[17];
                m_valid = 1'b1;
                m_calc  = 1'b0;
            end else if (fire) begin
                m_valid = 1'b0;
            end
            if (acc) begin
                m_calc = 1'b1;
                m_opnd = in_addr;
                m_op   = in_op;
                total_accepts++;
            end
        end
    end

    always @(negedge CLK) begin
        if (check_en) begin
            checkOutput("in_ready", in_ready, m_in_ready());
            checkOutput("out_valid", out_valid, m_valid);
            checkOutput("busy", busy, m_calc || m_valid);
            if (m_valid) begin
                checkOutput("out_addr", out_addr, m_addr);
                checkOutput("out_zero", out_zero, m_zero);
                checkOutput("out_wrap", out_wrap, m_wrap);
            end
        end
    end

    task automatic run_op(input logic [15:0] addr, input logic [1:0] op,
                          input logic [15:0] exp_addr, input bit exp_zero, input bit exp_wrap,
                          input string name);
        applyStimulus(1'b1, addr, op, 1'b1);
        @(negedge CLK);
        checkOutput({name, "_idle_ready"}, in_ready, 1);
        applyStimulus(1'b0, addr, op, 1'b1);
        @(negedge CLK);
        checkOutput({name, "_calc_ready"}, in_ready, 0);
        checkOutput({name, "_calc_valid"}, out_valid, 0);
        @(negedge CLK);
        checkOutput({name, "_valid"}, out_valid, 1);
        checkOutput({name, "_addr"}, out_addr, exp_addr);
        checkOutput({name, "_zero"}, out_zero, exp_zero);
        checkOutput({name, "_wrap"}, out_wrap, exp_wrap);
    endtask

    initial begin
        int base;
        int cyc;
        logic [15:0] a;

        n_RES = 1'b0;
        repeat (2) @(posedge CLK);
        check_en = 1'b1;
        #1 n_RES = 1'b1;
        @(negedge CLK);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_addr", out_addr, 16'h0000);
        checkOutput("rst_out_zero", out_zero, 0);
        checkOutput("rst_out_wrap", out_wrap, 0);

        run_op(16'h1234, 2'b01, 16'h1235, 1'b0, 1'b0, "inc1234");
        run_op(16'hFFFF, 2'b01, 16'h0000, 1'b1, 1'b1, "incFFFF");
        run_op(16'h0000, 2'b10, 16'hFFFF, 1'b0, 1'b1, "dec0000");
        run_op(16'h0001, 2'b10, 16'h0000, 1'b1, 1'b0, "dec0001");
        run_op(16'hABCD, 2'b11, 16'hABCD, 1'b0, 1'b0, "rsvdABCD");
        run_op(16'h00FF, 2'b01, 16'h0100, 1'b0, 1'b0, "inc00FF");

        // Write-back stalls with the next operand already waiting.
        applyStimulus(1'b1, 16'h0010, 2'b01, 1'b0);
        applyStimulus(1'b1, 16'h0020, 2'b10, 1'b0);
        @(posedge CLK);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checkOutput("stall_addr", out_addr, 16'h0011);
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_in_ready", in_ready, 0);
        end
        applyStimulus(1'b1, 16'h0020, 2'b10, 1'b1);
        @(negedge CLK);
        checkOutput("release_in_ready", in_ready, 1);
        applyStimulus(1'b0, 16'h0020, 2'b10, 1'b1);
        @(negedge CLK);
        checkOutput("b2b_calc_valid", out_valid, 0);
        checkOutput("b2b_calc_ready", in_ready, 0);
        checkOutput("b2b_busy", busy, 1);
        @(negedge CLK);
        checkOutput("b2b_valid", out_valid, 1);
        checkOutput("b2b_addr", out_addr, 16'h001F);

        // Reset while an operation is in CALC.
        applyStimulus(1'b1, 16'h5555, 2'b01, 1'b1);
        applyStimulus(1'b0, 16'h5555, 2'b01, 1'b1);
        n_RES = 1'b0;
        @(posedge CLK);
        #1 n_RES = 1'b1;
        @(negedge CLK);
        checkOutput("rstcalc_busy", busy, 0);
        checkOutput("rstcalc_valid", out_valid, 0);
        checkOutput("rstcalc_addr", out_addr, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checkOutput("rstcalc_no_result", out_valid, 0);
        end

        // Randomized regression with carry boundaries forced often.
        base = total_accepts;
        cyc  = 0;
        while ((total_accepts - base) < 10000 && cyc < 60000) begin
            case ($urandom_range(0, 9))
                0: a = 16'h00FF;
                1: a = 16'h0FFF;
                2: a = 16'h7FFF;
                3: a = 16'h8000;
                4: a = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
                5: a = 16'h0001;
                default: a = 16'($urandom);
            endcase
            applyStimulus($urandom_range(0, 9) < 9, a, 2'($urandom_range(0, 3)),
                          $urandom_range(0, 9) < 8);
            n_RES = ($urandom_range(0, 999) != 0);
            cyc++;
        end
        checkOutput("regression_count", ((total_accepts - base) >= 10000) ? 32'd1 : 32'd0, 1);

        applyStimulus(1'b0, 16'h0000, 2'b00, 1'b1);
        n_RES = 1'b1;
        repeat (4) @(negedge CLK);
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
